// File: rtl/mem_bridge_pkg.sv
// ============================================================================
// mem_bridge_pkg : shared types and helpers for the MEM-stage data-bus bridge
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package mem_bridge_pkg;

  localparam int MB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mb_state_t;

  // Byte, aligned halfword or full word only
  function automatic logic strb_legal(input logic [3:0] strb);
    case (strb)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bridge.sv
// ============================================================================
// mem_bridge : MIPS MEM-stage access to valid/ready data bus, stalls the core
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = MB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  mb_state_t   state_q, state_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_addr[1:0];

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (cpu_req) begin
          if (strb_legal(cpu_we)) begin
            bus_addr_d  = {cpu_addr[31:2], 2'b00};
            bus_wstrb_d = cpu_we;
            bus_wdata_d = cpu_wdata;
            bus_valid_d = 1'b1;
            state_d     = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        err_d = 1'b0;
        if (bus_ready) begin
          bus_valid_d = 1'b0;
          // Writes are posted: no response phase
          if (|bus_wstrb_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = 8'd0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A response arriving in the timeout cycle still wins
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wstrb_q <= 4'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpu_stall = cpu_req & (state_q != DONE);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;
  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bridge.sv
// ============================================================================
// tb_mem_bridge : directed scoreboard bench for mem_bridge (TIMEOUT = 4)
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_bridge #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_err    (cpu_err),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          last_gap = 0;
  logic [31:0] exp_rdata_hold = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      cpu_req    = 1'b0;
      cpu_we     = 4'd0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      #1;
      chk("idle_stall", 32'(cpu_stall), 32'd0);
    end
  endtask

  // One core access; rv_dly < 0 means the slave never responds
  task automatic do_access(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int rdy_dly,
                           input int rv_dly, input logic [31:0] rdata,
                           input logic exp_err, input int exp_vcyc,
                           input int exp_stall, input string tag);
    exp_t e;
    exp_t got;
    int   k;
    int   stalls;
    int   vcyc;
    int   acc;
    int   prev_done;
    bit   done;
    e.err = exp_err;
    if (exp_vcyc == 0 || we != 4'd0) e.rdata = exp_rdata_hold;
    else if (rv_dly < 0)             e.rdata = 32'd0;
    else                             e.rdata = rdata;
    exp_rdata_hold = e.rdata;
    sb.push_back(e);
    prev_done = last_done_cyc;
    k = 0; stalls = 0; vcyc = 0; acc = -1; done = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      cyc++;
      cpu_req    = 1'b1;
      cpu_we     = we;
      cpu_addr   = addr;
      cpu_wdata  = wdata;
      bus_ready  = (k >= 1 + rdy_dly);
      bus_rvalid = (rv_dly >= 0 && acc >= 0 && k == acc + rv_dly);
      bus_rdata  = bus_rvalid ? rdata : 32'hBAD0_0000 + 32'(k);
      #1;
      if (bus_valid) begin
        vcyc++;
        if (vcyc == 1) last_gap = cyc - prev_done;
        chk({tag, "_addr"},  bus_addr,  addr & 32'hFFFF_FFFC);
        chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'(we));
        chk({tag, "_wdata"}, bus_wdata, wdata);
        if (bus_ready) acc = k;
      end
      if (cpu_stall) begin
        stalls++;
      end else begin
        done = 1;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          chk({tag, "_err"},   32'(cpu_err), 32'(got.err));
          chk({tag, "_rdata"}, cpu_rdata,    got.rdata);
        end
      end
      k++;
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_valid_cycles"}, 32'(vcyc), 32'(exp_vcyc));
  endtask

  initial begin
    rst        = 1'b0;
    cpu_req    = 1'b1;
    cpu_we     = 4'b1111;
    cpu_addr   = 32'h0000_1234;
    cpu_wdata  = 32'hFFFF_FFFF;
    bus_ready  = 1'b1;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    #12;
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_bus_addr",  bus_addr,       32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_bus_wdata", bus_wdata,      32'd0);
    chk("rst_rdata",     cpu_rdata,      32'd0);
    chk("rst_err",       32'(cpu_err),   32'd0);
    chk("rst_stall_req1", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    #1;
    chk("rst_stall_req0", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    do_access(4'b1111, 32'h0000_1004, 32'hDEAD_BEEF, 0, -1, 32'd0, 1'b0, 1, 2, "wr_full");
    do_access(4'b0000, 32'h0000_2002, 32'd0, 3, 2, 32'h1234_5678, 1'b0, 4, 7, "rd_slow");
    idle(1);
    do_access(4'b0101, 32'h0000_3000, 32'h0000_0055, 0, -1, 32'd0, 1'b1, 0, 1, "bad_strb");
    idle(1);

    // Reset while waiting for a read response
    @(negedge clk); cyc++;
    cpu_req = 1'b1; cpu_we = 4'd0; cpu_addr = 32'h0000_4000; bus_ready = 1'b1;
    @(negedge clk); cyc++;
    @(negedge clk); cyc++;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_bus_valid", 32'(bus_valid), 32'd0);
    chk("arst_rdata",     cpu_rdata,      32'd0);
    chk("arst_err",       32'(cpu_err),   32'd0);
    chk("arst_stall",     32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    #1;
    chk("arst_stall_idle", 32'(cpu_stall), 32'd0);
    @(negedge clk); cyc++;
    rst = 1'b1; bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(negedge clk); cyc++;
    bus_rvalid = 1'b0;
    #1;
    chk("late_rvalid_rdata", cpu_rdata,      32'd0);
    chk("late_rvalid_err",   32'(cpu_err),   32'd0);
    chk("late_rvalid_valid", 32'(bus_valid), 32'd0);
    exp_rdata_hold = 32'd0;
    idle(1);

    do_access(4'b0011, 32'h0000_5006, 32'h0000_BEEF, 1, -1, 32'd0, 1'b0, 2, 3, "wr_half_lo");
    idle(1);
    do_access(4'b0000, 32'h0000_6000, 32'd0, 0, -1, 32'd0, 1'b1, 1, 6, "rd_tmo");
    idle(1);
    do_access(4'b0000, 32'h0000_8000, 32'd0, 0, 4, 32'h0BAD_CAFE, 1'b0, 1, 6, "rd_edge");
    idle(1);

    do_access(4'b0000, 32'h0000_7008, 32'd0, 0, 1, 32'hA5A5_0F0F, 1'b0, 1, 3, "b2b_rd");
    do_access(4'b1100, 32'h0000_700A, 32'h1234_0000, 0, -1, 32'd0, 1'b0, 1, 2, "b2b_wr");
    chk("b2b_gap", 32'(last_gap), 32'd2);
    idle(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
